mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. This includes the unconditional PC write and the branch qualifier that are OR-combined downstream into the final PC write enable. It adds a memory-ready handshake so fetch and data accesses can stall on slow memory.

Parameters:
OP_W, 6, opcode field width (instr[31:26])
ST_W, 4, state register width

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
op  input  OP_W  opcode from instruction register
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC write
branch  output  1  conditional PC write; qualified by ALU zero downstream
iord  output  1  0 = memory address from PC, 1 = from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
reg_write  output  1  register file write
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = use funct
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  output  ST_W  current state, for debug

Behaviour:
- Moore FSM. Outputs are decoded from the state register only, except where mem_ready gating is listed below.
- Reset:
  - rst=1 at a rising edge sets state to FETCH.
  - While rst=1, every output except state_o is forced to 0.
  - rst overrides any in-progress instruction. No partial writes occur in the reset cycle.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- States, with non-zero outputs and next state:
  - FETCH(0): mem_read, alu_src_b=01, alu_op=00, pc_source=00, iord=0.
    - pc_write and ir_write are asserted only when mem_ready=1.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - lw/sw -> MEMADR
    - R -> EXEC
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - other -> FETCH, with illegal_op=1 for this cycle only.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if op=lw, otherwise MEMWR.
  - MEMRD(3): mem_read, iord=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. Goes to FETCH.
  - MEMWR(5): mem_write, iord=1. Holds until mem_ready=1, then goes to FETCH. mem_write stays asserted for every stall cycle.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_source=01. Goes to FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
  - ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - JUMP(11): pc_write, pc_source=10. Goes to FETCH.
  - Encodings 12-15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- pc_write and branch are never both 1 in the same cycle.
- Instruction latency in cycles with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- op is sampled only in DECODE and MEMADR. The IR is stable in those states.

Decomposition:
- Package mc_pkg holds:
  - state localparams S_FETCH..S_JUMP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALU_OP_*, SRCB_*, PCSRC_* encodings
- One natural sub-module, mc_ctrl_decode: purely combinational map from (state, mem_ready, rst) to the output vector. The top holds the state register and the next-state logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with op=lw and mem_ready=1 -> all outputs 0 and state_o=0. On the first cycle after release: mem_read=1, pc_write=1, ir_write=1.
- lw with mem_ready=1: op=100011 -> state_o sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Total 5 cycles.
- beq then j: op=000100 -> states 0,1,8, with branch=1 and pc_source=01 in state 8 and pc_write=0 there. Then op=000010 -> states 0,1,11, with pc_write=1 and pc_source=10 in state 11.
- Memory stalls: sw with mem_ready low for 3 cycles in MEMWR -> state 5 held for 4 cycles with mem_write=1 on each, then FETCH. In FETCH, mem_ready=0 for 2 cycles -> pc_write=0 on both, then exactly one pc_write pulse.
- Illegal opcode: op=111111 -> state 1 with illegal_op=1 for exactly one cycle, next state 0, and no reg_write or mem_write ever asserted.
- Reset mid-operation: assert rst while in MEMRD with mem_ready=0 -> next state 0, with mem_read=0 during the reset cycle. Also drive R-type then addi back-to-back -> states 0,1,6,7,0,1,9,10, with reg_dst=1 in state 7 and reg_dst=0 in state 10.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller:
// state encodings, opcodes, datapath select encodings and the control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode for the main controller: a pure function
// of the current state, with mem_ready gating only the FETCH-cycle writes.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   rst,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // PC and IR only load on the cycle the instruction word arrives.
          ctrl.pc_write  = mem_ready;
          ctrl.ir_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALU_OP_ADD;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_OP_ADD;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_OP_SUB;
          ctrl.branch    = 1'b1;
          ctrl.pc_source = PCSRC_ALUOUT;
        end
        S_ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_OP_ADD;
        end
        S_ADDIWB: begin
          ctrl.reg_write = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and illegal-opcode detection around the control decode.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            branch,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic [ST_W-1:0] state_o
);

  // Memory handshake: mem_read/mem_write and iord are held steady by the
  // state; the access completes on a rising edge where mem_ready=1, and
  // every cycle with mem_ready=0 keeps the FSM in the same state.
  state_t state_q, state_d;
  logic   illegal_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_d = !op_supported(op);
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .rst       (rst),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal_op = illegal_d & ~rst;
  assign state_o    = ST_W'(state_q);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: walks each instruction class, memory
// stalls, illegal opcode and mid-instruction reset with hand-computed values.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op;
  logic [3:0] state_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mc_main_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
            illegal_op, 1'b0};
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("pc_branch_excl", {31'd0, pc_write & branch}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op = 6'b100011; mem_ready = 1'b1;
    #1;
    chk("rst_outs_async", {14'd0, all_outs()}, 32'd0);
    tick();
    chk("rst_state_c1", {28'd0, state_o}, 32'd0);
    chk("rst_outs_c1",  {14'd0, all_outs()}, 32'd0);
    tick();
    chk("rst_state_c2", {28'd0, state_o}, 32'd0);
    chk("rst_outs_c2",  {14'd0, all_outs()}, 32'd0);

    // First cycle after release: FETCH with memory ready.
    rst = 1'b0;
    #1;
    chk("rel_fetch", {29'd0, mem_read, pc_write, ir_write}, 32'h7);
    chk("rel_srcb",  {30'd0, alu_src_b}, 32'd1);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_s1", {28'd0, state_o}, 32'd1);
    chk("lw_s1_srcb", {30'd0, alu_src_b}, 32'd3);
    chk("lw_s1_rw", {31'd0, reg_write}, 32'd0);
    tick(); chk("lw_s2", {28'd0, state_o}, 32'd2);
    chk("lw_s2_ctl", {27'd0, alu_src_a, alu_src_b, alu_op}, 32'b11000);
    tick(); chk("lw_s3", {28'd0, state_o}, 32'd3);
    chk("lw_s3_ctl", {29'd0, mem_read, iord, reg_write}, 32'b110);
    tick(); chk("lw_s4", {28'd0, state_o}, 32'd4);
    chk("lw_s4_ctl", {29'd0, reg_write, mem_to_reg, reg_dst}, 32'b110);
    tick(); chk("lw_s0", {28'd0, state_o}, 32'd0);
    chk("lw_s0_rw", {30'd0, reg_write, mem_to_reg}, 32'd0);

    // beq: 0,1,8
    op = 6'b000100;
    tick(); chk("beq_s1", {28'd0, state_o}, 32'd1);
    tick(); chk("beq_s8", {28'd0, state_o}, 32'd8);
    chk("beq_ctl", {27'd0, branch, pc_source, pc_write, alu_op[0]}, 32'b10101);
    tick(); chk("beq_s0", {28'd0, state_o}, 32'd0);

    // j: 0,1,11
    op = 6'b000010;
    tick(); chk("j_s1", {28'd0, state_o}, 32'd1);
    tick(); chk("j_s11", {28'd0, state_o}, 32'd11);
    chk("j_ctl", {28'd0, pc_write, pc_source, branch}, 32'b1100);
    tick(); chk("j_s0", {28'd0, state_o}, 32'd0);

    // sw with three stall cycles in MEMWR
    op = 6'b101011;
    tick(); chk("sw_s1", {28'd0, state_o}, 32'd1);
    tick(); chk("sw_s2", {28'd0, state_o}, 32'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall_state", {28'd0, state_o}, 32'd5);
      chk("sw_stall_mw", {30'd0, mem_write, iord}, 32'b11);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_last_state", {28'd0, state_o}, 32'd5);
    chk("sw_last_mw", {31'd0, mem_write}, 32'd1);
    tick(); chk("sw_s0", {28'd0, state_o}, 32'd0);
    chk("sw_s0_mw", {31'd0, mem_write}, 32'd0);

    // FETCH stall for two cycles, then an illegal opcode
    mem_ready = 1'b0;
    #1;
    chk("fst_c1", {29'd0, mem_read, pc_write, ir_write}, 32'b100);
    tick();
    chk("fst_c2_state", {28'd0, state_o}, 32'd0);
    chk("fst_c2", {30'd0, pc_write, ir_write}, 32'd0);
    tick();
    chk("fst_c3_state", {28'd0, state_o}, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("fst_pulse", {30'd0, pc_write, ir_write}, 32'b11);
    op = 6'b111111;
    tick();
    chk("ill_s1", {28'd0, state_o}, 32'd1);
    chk("ill_pulse", {29'd0, illegal_op, reg_write, mem_write}, 32'b100);
    tick();
    chk("ill_s0", {28'd0, state_o}, 32'd0);
    chk("ill_clear", {29'd0, illegal_op, reg_write, mem_write}, 32'd0);

    // Reset while stalled in MEMRD
    op = 6'b100011;
    tick(); tick(); tick();
    chk("rmid_s3", {28'd0, state_o}, 32'd3);
    mem_ready = 1'b0;
    #1;
    chk("rmid_rd", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_rd_rst", {31'd0, mem_read}, 32'd0);
    chk("rmid_outs_rst", {14'd0, all_outs()}, 32'd0);
    tick();
    chk("rmid_s0", {28'd0, state_o}, 32'd0);
    rst = 1'b0; mem_ready = 1'b1;

    // R-type then addi back to back: 0,1,6,7,0,1,9,10,0
    op = 6'b000000;
    tick(); chk("r_s1", {28'd0, state_o}, 32'd1);
    tick(); chk("r_s6", {28'd0, state_o}, 32'd6);
    chk("r_s6_ctl", {27'd0, alu_src_a, alu_src_b, alu_op}, 32'b10010);
    tick(); chk("r_s7", {28'd0, state_o}, 32'd7);
    chk("r_s7_ctl", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b110);
    tick(); chk("r_s0", {28'd0, state_o}, 32'd0);
    op = 6'b001000;
    tick(); chk("addi_s1", {28'd0, state_o}, 32'd1);
    tick(); chk("addi_s9", {28'd0, state_o}, 32'd9);
    chk("addi_s9_ctl", {27'd0, alu_src_a, alu_src_b, alu_op}, 32'b11000);
    tick(); chk("addi_s10", {28'd0, state_o}, 32'd10);
    chk("addi_s10_ctl", {29'd0, reg_write, reg_dst, mem_to_reg}, 32'b100);
    tick(); chk("addi_s0", {28'd0, state_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
